// File: rtl/input_capture_unit.sv
// Timer input-capture stage.
// Synchronizes the external capture pin, detects the selected edge and
// timestamps it with the live counter value into a small show-ahead FIFO.
// Optional noise filter: define CAP_NOISE_FILTER_EN to insert a FILT_LEN-sample
// majority-free (all-equal) glitch filter between the synchronizer and the
// edge detector.
module input_capture_unit #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                          i_sysclk,
  input  logic                          i_sysrst_n,
  input  logic                          i_cap_pin,
  input  logic                          i_cap_en,
  input  logic                          i_cap_clr,
  input  logic [1:0]                    i_edge_sel,
  input  logic [15:0]                   i_cnt_data,
  input  logic                          i_cap_rd,
  output logic                          o_cap_ic_flg,
  output logic [15:0]                   o_cap_cnt_data,
  output logic                          o_cap_ovr,
  output logic [$clog2(FIFO_DEPTH):0]   o_cap_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_e;

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 2) begin : g_bad_filt
    $error("FILT_LEN must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic                   edge_src;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;
  logic                   hit;

  logic [15:0]            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic                   ovr_q;
  logic                   empty;
  logic                   full;
  logic                   do_pop;
  logic                   do_push;

  // Metastability synchronizer chain on the asynchronous capture pin.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      sync_ff <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, forming a real shift chain.
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], i_cap_pin};
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

`ifdef CAP_NOISE_FILTER_EN
  // The window holds the FILT_LEN most recent synchronized samples; the
  // newest one is sync_q itself, so only FILT_LEN-1 extra flops are needed.
  logic [FILT_LEN-2:0] filt_sr;
  logic [FILT_LEN-1:0] filt_win;
  logic                filt_lvl;

  assign filt_win = {filt_sr, sync_q};

  // Filtered level follows the pin only once all window samples agree.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      filt_sr  <= '0;
      filt_lvl <= 1'b0;
    end else begin
      filt_sr <= filt_win[FILT_LEN-2:0];
      if (&filt_win) begin
        filt_lvl <= 1'b1;
      end else if (~|filt_win) begin
        filt_lvl <= 1'b0;
      end
    end
  end

  assign edge_src = filt_lvl;
`else
  assign edge_src = sync_q;
`endif

  // Previous-sample register tracks the level even while capture is disabled,
  // so enabling with the pin already high does not fake an edge.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= edge_src;
    end
  end

  assign rise = edge_src & ~prev_q;
  assign fall = ~edge_src & prev_q;

  // Edge qualification against the selected polarity.
  always_comb begin
    // NOTE: default first so every path assigns hit and no latch is inferred.
    hit = 1'b0;
    unique case (edge_sel_e'(i_edge_sel))
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      EDGE_NONE: hit = 1'b0;
    endcase
    hit = hit & i_cap_en;
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_L);
  assign do_pop  = i_cap_rd & ~empty & ~i_cap_clr;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign do_push = hit & (~full | do_pop) & ~i_cap_clr;

  // Timestamp storage; contents are never visible while empty.
  always_ff @(posedge i_sysclk) begin
    // NOTE: storage array is deliberately left unreset; the output gating on
    // empty hides stale data, and an unreset array maps onto plain RAM.
    if (do_push) begin
      mem[wr_ptr] <= i_cnt_data;
    end
  end

  // Pointer, occupancy and sticky overrun bookkeeping; clear wins over all.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else if (i_cap_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (hit && full && !do_pop) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign o_cap_ic_flg   = ~empty;
  assign o_cap_cnt_data = empty ? 16'h0000 : mem[rd_ptr];
  assign o_cap_ovr      = ovr_q;
  assign o_cap_level    = count;

endmodule

// File: tb/tb_input_capture_unit.sv
// Self-checking bench for input_capture_unit: directed table, hand-written
// corner sequences and randomized stimulus against a history-based model.
module tb_input_capture_unit;

  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int F     = 4;
  localparam int MAXN  = 8192;

  logic        i_sysclk = 1'b0;
  logic        i_sysrst_n;
  logic        i_cap_pin;
  logic        i_cap_en;
  logic        i_cap_clr;
  logic [1:0]  i_edge_sel;
  logic [15:0] i_cnt_data;
  logic        i_cap_rd;
  logic        o_cap_ic_flg;
  logic [15:0] o_cap_cnt_data;
  logic        o_cap_ovr;
  logic [2:0]  o_cap_level;

  input_capture_unit #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(S),
    .FILT_LEN   (F)
  ) dut (
    .i_sysclk      (i_sysclk),
    .i_sysrst_n    (i_sysrst_n),
    .i_cap_pin     (i_cap_pin),
    .i_cap_en      (i_cap_en),
    .i_cap_clr     (i_cap_clr),
    .i_edge_sel    (i_edge_sel),
    .i_cnt_data    (i_cnt_data),
    .i_cap_rd      (i_cap_rd),
    .o_cap_ic_flg  (o_cap_ic_flg),
    .o_cap_cnt_data(o_cap_cnt_data),
    .o_cap_ovr     (o_cap_ovr),
    .o_cap_level   (o_cap_level)
  );

  always #5 i_sysclk = ~i_sysclk;

  // Model state: pin value sampled at each edge, level seen by the edge
  // detector before each edge, and the timestamp queue.
  bit          ph [MAXN];
  bit          fl [MAXN];
  logic [15:0] q [$];
  bit          m_ovr;
  int          n;
  int          errors;
  int          checks;
  bit          cur_pin;

  typedef struct {
    bit         pin;
    bit         rd;
    bit         clr;
    logic [2:0] lvl;
    bit         ovr;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  // Synchronized pin value as seen during the cycle ending with edge j.
  function automatic bit sync_at(input int j);
    return (j - S >= 1) ? ph[j - S] : 1'b0;
  endfunction

  task automatic compare_model();
    check("flg",   o_cap_ic_flg, q.size() > 0);
    check("level", o_cap_level, q.size());
    check("data",  o_cap_cnt_data, (q.size() > 0) ? q[0] : 16'h0000);
    check("ovr",   o_cap_ovr, m_ovr);
  endtask

  // One clock cycle: drive inputs, advance model at the edge, compare later.
  task automatic step(input bit pin, input bit en, input logic [1:0] sel,
                      input bit rd, input bit clr);
    bit cur, prv, rise, fall, hit, same;
    n++;
    cur_pin    = pin;
    i_cap_pin  = pin;
    i_cap_en   = en;
    i_edge_sel = sel;
    i_cap_rd   = rd;
    i_cap_clr  = clr;
    i_cnt_data = 16'h0100 + 16'(n);
    ph[n] = pin;
`ifndef CAP_NOISE_FILTER_EN
    fl[n] = sync_at(n);
`endif
    cur  = fl[n];
    prv  = fl[n-1];
    rise = cur & ~prv;
    fall = ~cur & prv;
    case (sel)
      2'b00:   hit = rise;
      2'b01:   hit = fall;
      2'b10:   hit = rise | fall;
      default: hit = 1'b0;
    endcase
    hit = hit & en;
    @(posedge i_sysclk);
    if (clr) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (hit) begin
        if (q.size() < DEPTH) q.push_back(16'h0100 + 16'(n));
        else m_ovr = 1'b1;
      end
    end
`ifdef CAP_NOISE_FILTER_EN
    same = 1'b1;
    for (int k = 0; k < F; k++) if (sync_at(n - k) != sync_at(n)) same = 1'b0;
    fl[n+1] = same ? sync_at(n) : fl[n];
`endif
    @(negedge i_sysclk);
    compare_model();
  endtask

  task automatic hold(input int cnt);
    for (int k = 0; k < cnt; k++) step(cur_pin, 1'b1, 2'b10, 1'b0, 1'b0);
  endtask

  // Each toggle is followed by one hold cycle, so edges never share a cycle.
  task automatic toggles(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      step(~cur_pin, 1'b1, 2'b10, 1'b0, 1'b0);
      step(cur_pin,  1'b1, 2'b10, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset(input bit pin);
    i_sysrst_n = 1'b0;
    i_cap_pin  = pin;
    i_cap_en   = 1'b0;
    i_cap_clr  = 1'b0;
    i_edge_sel = 2'b00;
    i_cnt_data = 16'h0000;
    i_cap_rd   = 1'b0;
    cur_pin    = pin;
    foreach (ph[i]) ph[i] = 1'b0;
    foreach (fl[i]) fl[i] = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    n = 0;
    repeat (3) @(negedge i_sysclk);
    check("rst_flg",   o_cap_ic_flg, 1'b0);
    check("rst_data",  o_cap_cnt_data, 16'h0000);
    check("rst_ovr",   o_cap_ovr, 1'b0);
    check("rst_level", o_cap_level, 3'd0);
    i_sysrst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] last_ts;
    errors = 0;
    checks = 0;

    do_reset(1'b0);

    // Rising edge latency: pin goes high for edge 11, timestamp lands at edge 13.
    for (int e = 1; e <= 10; e++) step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    check("lat_early_level", o_cap_level, 3'd0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    check("lat_level", o_cap_level, 3'd1);
    check("lat_flg",   o_cap_ic_flg, 1'b1);
    check("lat_data",  o_cap_cnt_data, 16'h010D);

    // Both-edge table: six toggles, two dropped, then drained in order.
    tbl = '{
      '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0},
      '{1'b1, 1'b0, 1'b0, 3'd3, 1'b0},
      '{1'b1, 1'b0, 1'b0, 3'd3, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0},
      '{1'b1, 1'b0, 1'b0, 3'd4, 1'b1},
      '{1'b1, 1'b0, 1'b0, 3'd4, 1'b1},
      '{1'b1, 1'b0, 1'b0, 3'd4, 1'b1},
      '{1'b1, 1'b1, 1'b0, 3'd3, 1'b1},
      '{1'b1, 1'b1, 1'b0, 3'd2, 1'b1},
      '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1},
      '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1}
    };
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].pin, 1'b1, 2'b10, tbl[i].rd, tbl[i].clr);
      check("tbl_level", o_cap_level, tbl[i].lvl);
      check("tbl_ovr",   o_cap_ovr, tbl[i].ovr);
      check("tbl_flg",   o_cap_ic_flg, tbl[i].lvl != 3'd0);
    end

    // Full FIFO with a pop and a new write on the same edge.
    step(cur_pin, 1'b1, 2'b10, 1'b0, 1'b1);
    toggles(4);
    hold(1);
    check("full_level", o_cap_level, 3'd4);
    step(~cur_pin, 1'b1, 2'b10, 1'b0, 1'b0);
    hold(1);
    step(cur_pin, 1'b1, 2'b10, 1'b1, 1'b0);
    last_ts = 16'h0100 + 16'(n);
    check("wrpop_level", o_cap_level, 3'd4);
    check("wrpop_ovr",   o_cap_ovr, 1'b0);
    for (int k = 0; k < 3; k++) step(cur_pin, 1'b1, 2'b10, 1'b1, 1'b0);
    check("wrpop_last", o_cap_cnt_data, last_ts);
    step(cur_pin, 1'b1, 2'b10, 1'b1, 1'b0);
    check("drain_flg",  o_cap_ic_flg, 1'b0);
    check("drain_data", o_cap_cnt_data, 16'h0000);

    // Clear coincident with a write and a pop on a full, overrun FIFO.
    toggles(4);
    hold(1);
    step(~cur_pin, 1'b1, 2'b10, 1'b0, 1'b0);
    hold(2);
    check("ovr_set", o_cap_ovr, 1'b1);
    step(~cur_pin, 1'b1, 2'b10, 1'b0, 1'b0);
    hold(1);
    step(cur_pin, 1'b1, 2'b10, 1'b1, 1'b1);
    check("clr_level", o_cap_level, 3'd0);
    check("clr_ovr",   o_cap_ovr, 1'b0);
    hold(3);
    check("clr_after_level", o_cap_level, 3'd0);

    // Pin raised while disabled, then enabled with the pin still high.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    check("en_late_level", o_cap_level, 3'd0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    check("rd_empty_level", o_cap_level, 3'd0);
    check("rd_empty_flg",   o_cap_ic_flg, 1'b0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bit p;
      p = cur_pin;
`ifdef CAP_NOISE_FILTER_EN
      if ($urandom_range(5) == 0) p = ~p;
`else
      if ($urandom_range(2) == 0) p = ~p;
`endif
      step(p, $urandom_range(7) != 0, 2'($urandom_range(3)),
           $urandom_range(2) == 0, $urandom_range(39) == 0);
    end

    // Pin held high through reset gives exactly one rising edge after release.
    do_reset(1'b1);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    check("rst_high_level", o_cap_level, 3'd1);

`ifdef CAP_NOISE_FILTER_EN
    // Short pulse rejected, pulse of exactly FILT_LEN cycles accepted.
    do_reset(1'b0);
    for (int k = 0; k < 5; k++)  step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)  step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    check("filt_short_level", o_cap_level, 3'd0);
    for (int k = 0; k < 4; k++)  step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < S + F - 4; k++) step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    check("filt_early_level", o_cap_level, 3'd0);
    step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    check("filt_level", o_cap_level, 3'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
